// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: issues one word read at a time and queues {pc, opcode} pairs for decode.
// Optional fetch/flush statistics counters are enabled with `define FETCH_STATS_EN.
module inst_fetch_queue #(
   parameter int DEPTH = 2,
   parameter int AW    = 30
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc_current,
   input  logic          redirect,
   output logic          pc_advance,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output logic          op_valid,
   input  logic          op_ready,
   output logic [31:0]   opcode,
   output logic [AW-1:0] op_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]   fetch_cnt,
   output logic [31:0]   flush_cnt
`else
   // statistics ports absent in this build
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            issue;
   logic            push;
   logic            pop;
   logic            req_done;
   logic            advance_nxt;

   logic [AW-1:0]   pc_mem [DEPTH];
   logic [31:0]     op_mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   // IDLE never issues while pc_advance is high: pc_current has not stepped yet.
   always_comb begin
      state_nxt   = state;
      issue       = 1'b0;
      push        = 1'b0;
      req_done    = 1'b0;
      advance_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (!redirect && !pc_advance && (count < FULL_COUNT)) begin
               issue     = 1'b1;
               state_nxt = REQ;
            end else begin
               state_nxt = IDLE;
            end
         end
         REQ: begin
            if (redirect) begin
               req_done  = 1'b1;
               state_nxt = mem_ack ? IDLE : DISCARD;
            end else if (mem_ack) begin
               push        = 1'b1;
               advance_nxt = 1'b1;
               req_done    = 1'b1;
               state_nxt   = IDLE;
            end else begin
               state_nxt = REQ;
            end
         end
         DISCARD: begin
            // an ack here consumes the abandoned request even if another redirect arrives
            if (mem_ack) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = DISCARD;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign op_valid = (count != {CW{1'b0}});
   assign pop      = op_valid && op_ready && !redirect;
   assign opcode   = op_mem[rd_ptr];
   assign op_pc    = pc_mem[rd_ptr];

   // State register and registered memory-port / pc_advance outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         mem_addr   <= {AW{1'b0}};
         pc_advance <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc_advance <= advance_nxt;
         if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= pc_current;
         end else if (req_done) begin
            mem_req  <= 1'b0;
         end else begin
            mem_req  <= mem_req;
         end
      end
   end

   // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || redirect) begin
         wr_ptr <= {PW{1'b0}};
         rd_ptr <= {PW{1'b0}};
         count  <= {CW{1'b0}};
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; cleared on reset so the head reads zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i] <= {AW{1'b0}};
            op_mem[i] <= 32'd0;
         end
      end else if (push) begin
         pc_mem[wr_ptr] <= mem_addr;
         op_mem[wr_ptr] <= mem_rdata;
      end
   end

`ifdef FETCH_STATS_EN
   // Free-running push and redirect counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (push) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (redirect) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`else
   // no statistics counters in this build
`endif

endmodule
